// File: rtl/dm_responder_pkg.sv
// Shared constants, state encoding and lane helpers for the data-memory responder.
package dm_responder_pkg;

    localparam int DM_DEPTH_WORDS = 3072;
    localparam int DM_IDX_W       = 12;

    typedef enum logic {
        DM_ST_CLEAR = 1'b0,
        DM_ST_READY = 1'b1
    } dm_state_e;

    localparam logic [3:0] DM_BE_NONE = 4'b0000;
    localparam logic [3:0] DM_BE_WORD = 4'b1111;
    localparam logic [3:0] DM_BE_HLO  = 4'b0011;
    localparam logic [3:0] DM_BE_HHI  = 4'b1100;
    localparam logic [3:0] DM_BE_B0   = 4'b0001;
    localparam logic [3:0] DM_BE_B1   = 4'b0010;
    localparam logic [3:0] DM_BE_B2   = 4'b0100;
    localparam logic [3:0] DM_BE_B3   = 4'b1000;

    function automatic logic [31:0] dm_lane_mask(input logic [3:0] byteen);
        logic [31:0] mask;
        mask = {{8{byteen[3]}}, {8{byteen[2]}}, {8{byteen[1]}}, {8{byteen[0]}}};
        return mask;
    endfunction

endpackage

// File: rtl/dm_responder_byte_merge.sv
// Combinational lane merge plus byte-enable/alignment legality check.
module dm_byte_merge
    import dm_responder_pkg::*;
(
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_byteen,
    input  logic [1:0]  i_addr_lo,
    output logic [31:0] o_merged,
    output logic        o_legal
);

    logic [31:0] w_mask;

    assign w_mask   = dm_lane_mask(i_byteen);
    assign o_merged = (i_old_word & ~w_mask) | (i_wdata & w_mask);

    // Each enable pattern is legal only at the one alignment that selects its lanes
    always_comb begin
        o_legal = 1'b0;
        case (i_byteen)
            DM_BE_NONE: o_legal = 1'b1;
            DM_BE_WORD: o_legal = (i_addr_lo == 2'b00);
            DM_BE_HLO:  o_legal = (i_addr_lo == 2'b00);
            DM_BE_HHI:  o_legal = (i_addr_lo == 2'b10);
            DM_BE_B0:   o_legal = (i_addr_lo == 2'b00);
            DM_BE_B1:   o_legal = (i_addr_lo == 2'b01);
            DM_BE_B2:   o_legal = (i_addr_lo == 2'b10);
            DM_BE_B3:   o_legal = (i_addr_lo == 2'b11);
            default:    o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: byte-lane writes, combinational reads, post-reset clear sweep.
// Define DM_WRITE_LOG_EN to print one line per committed bus write.
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = DM_DEPTH_WORDS,
    parameter int IDX_W       = DM_IDX_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    input  logic [31:0] m_inst_addr,
    output logic [31:0] m_data_rdata,
    output logic        busy,
    output logic        addr_err
);

    logic [31:0]      r_mem [DEPTH_WORDS];
    dm_state_e        r_state;
    dm_state_e        w_state_nxt;
    logic [IDX_W-1:0] r_clr_ptr;
    logic [IDX_W-1:0] w_clr_ptr_nxt;
    logic             r_addr_err;

    logic [IDX_W-1:0] w_idx;
    logic             w_in_range;
    logic             w_legal;
    logic             w_busy;
    logic             w_bus_wr;
    logic             w_commit;
    logic             w_reject;
    logic [31:0]      w_old;
    logic [31:0]      w_merged;
    logic             w_wr_en;
    logic [IDX_W-1:0] w_wr_idx;
    logic [31:0]      w_wr_data;

    assign w_idx      = m_data_addr[IDX_W+1:2];
    assign w_in_range = ((m_data_addr >> 2) < 32'(DEPTH_WORDS)) &&
                        (m_data_addr[31:IDX_W+2] == {(30-IDX_W){1'b0}});
    assign w_old      = w_in_range ? r_mem[w_idx] : 32'h0000_0000;
    assign w_busy     = (r_state == DM_ST_CLEAR);
    assign w_bus_wr   = !w_busy && (m_data_byteen != 4'b0000);
    assign w_commit   = w_bus_wr && w_in_range && w_legal;
    assign w_reject   = w_bus_wr && !(w_in_range && w_legal);

    dm_byte_merge u_merge (
        .i_old_word (w_old),
        .i_wdata    (m_data_wdata),
        .i_byteen   (m_data_byteen),
        .i_addr_lo  (m_data_addr[1:0]),
        .o_merged   (w_merged),
        .o_legal    (w_legal)
    );

    // Clear sweep advances one word per cycle and hands over to READY after the last word
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_ptr_nxt = r_clr_ptr;
        case (r_state)
            DM_ST_CLEAR: begin
                if (r_clr_ptr == IDX_W'(DEPTH_WORDS - 1)) begin
                    w_state_nxt   = DM_ST_READY;
                    w_clr_ptr_nxt = {IDX_W{1'b0}};
                end else begin
                    w_state_nxt   = DM_ST_CLEAR;
                    w_clr_ptr_nxt = r_clr_ptr + IDX_W'(1);
                end
            end
            DM_ST_READY: begin
                w_state_nxt   = DM_ST_READY;
                w_clr_ptr_nxt = {IDX_W{1'b0}};
            end
            default: begin
                w_state_nxt   = DM_ST_CLEAR;
                w_clr_ptr_nxt = {IDX_W{1'b0}};
            end
        endcase
    end

    // Single array write port shared between the clear sweep and bus writes
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_idx  = w_idx;
        w_wr_data = w_merged;
        if (reset) begin
            w_wr_en = 1'b0;
        end else if (w_busy) begin
            w_wr_en   = 1'b1;
            w_wr_idx  = r_clr_ptr;
            w_wr_data = 32'h0000_0000;
        end else begin
            w_wr_en   = w_commit;
            w_wr_idx  = w_idx;
            w_wr_data = w_merged;
        end
    end

    // State, sweep pointer and sticky error register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= DM_ST_CLEAR;
            r_clr_ptr  <= {IDX_W{1'b0}};
            r_addr_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_ptr  <= w_clr_ptr_nxt;
            r_addr_err <= r_addr_err | w_reject;
        end
    end

    // Word array storage
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= w_wr_data;
        end
    end

`ifdef DM_WRITE_LOG_EN
    // Trace of committed bus writes with the merged word
    always_ff @(posedge clk) begin
        if (!reset && w_commit) begin
            $display("%0t@%08h: *%08h <= %08h", $time, m_inst_addr,
                     {m_data_addr[31:2], 2'b00}, w_merged);
        end
    end
`else
    logic w_unused_pc;
    assign w_unused_pc = ^m_inst_addr;
`endif

    assign m_data_rdata = w_busy ? 32'h0000_0000 : w_old;
    assign busy         = w_busy;
    assign addr_err     = r_addr_err;

endmodule
